// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: single-port framebuffer arbiter between the VGA display
// read stream (absolute priority) and a single writer. Display reads have a
// fixed three-enabled-cycle latency from scan position to pix_data. Sync
// signals are delayed to stay aligned with the pixels.
// Optional feature: define VGA_ARB_VBLANK_ONLY_EN to restrict write grants to
// vertical blanking (vertical_sync high or vga_row >= 480) for tear-free
// updates. Without it, writes use any cycle with no display read.
module vga_fb_arbiter (
    input  logic        CLKIN,
    input  logic        reset,
    input  logic        clock_enable,
    input  logic        pixel_valid,
    input  logic [9:0]  vga_row,
    input  logic [9:0]  vga_col,
    input  logic        horizontal_sync,
    input  logic        vertical_sync,
    output logic [18:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        wr_req,
    input  logic [18:0] wr_addr,
    input  logic [7:0]  wr_data,
    output logic        wr_ack,
    output logic [7:0]  pix_data,
    output logic        pix_valid,
    output logic        hsync_out,
    output logic        vsync_out
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} arb_state_t;

    arb_state_t  state;
    arb_state_t  next_state;

    logic        in_range;
    logic        display_read;
    logic        write_window;
    logic [18:0] row_ext;
    logic [18:0] read_addr;

    logic [18:0] addr_d;
    logic [7:0]  wdata_d;
    logic        we_d;
    logic        ack_d;

    logic        valid_s1, hit_s1, hs_s1, vs_s1;
    logic        valid_s2, hit_s2, hs_s2, vs_s2;

    assign in_range     = (vga_row < 10'd480) && (vga_col < 10'd640);
    assign display_read = pixel_valid && in_range;
    assign row_ext      = {9'd0, vga_row};
    assign read_addr    = (row_ext << 9) + (row_ext << 7) + {9'd0, vga_col};

`ifdef VGA_ARB_VBLANK_ONLY_EN
    assign write_window = vertical_sync || (vga_row >= 10'd480);
`else
    assign write_window = 1'b1;
`endif

    // State and memory-port registers; reset abandons any write not yet issued.
    always_ff @(posedge CLKIN) begin
        if (reset) begin
            state     <= IDLE;
            mem_addr  <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            wr_ack    <= 1'b0;
        end else if (clock_enable) begin
            state     <= next_state;
            mem_addr  <= addr_d;
            mem_we    <= we_d;
            mem_wdata <= wdata_d;
            wr_ack    <= ack_d;
        end
    end

    // Next state: display first, a guard cycle after every write, then writer.
    always_comb begin
        next_state = IDLE;
        if (display_read) begin
            next_state = READ;
        end else if (state == WRITE) begin
            next_state = HOLD;
        end else if (pixel_valid) begin
            next_state = IDLE;
        end else if (wr_req && write_window && (state != HOLD)) begin
            next_state = WRITE;
        end
    end

    // Memory-port values to register for the state about to be entered.
    always_comb begin
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        we_d    = 1'b0;
        ack_d   = 1'b0;
        case (next_state)
            READ: begin
                addr_d = read_addr;
            end
            WRITE: begin
                addr_d  = wr_addr;
                wdata_d = wr_data;
                we_d    = 1'b1;
                ack_d   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Display delay line: scan info rides alongside the read until data returns.
    always_ff @(posedge CLKIN) begin
        if (reset) begin
            valid_s1  <= 1'b0;
            hit_s1    <= 1'b0;
            hs_s1     <= 1'b0;
            vs_s1     <= 1'b0;
            valid_s2  <= 1'b0;
            hit_s2    <= 1'b0;
            hs_s2     <= 1'b0;
            vs_s2     <= 1'b0;
            pix_valid <= 1'b0;
            pix_data  <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else if (clock_enable) begin
            valid_s1  <= pixel_valid;
            hit_s1    <= display_read;
            hs_s1     <= horizontal_sync;
            vs_s1     <= vertical_sync;
            valid_s2  <= valid_s1;
            hit_s2    <= hit_s1;
            hs_s2     <= hs_s1;
            vs_s2     <= vs_s1;
            pix_valid <= valid_s2;
            pix_data  <= (valid_s2 && hit_s2) ? mem_rdata : 8'd0;
            hsync_out <= hs_s2;
            vsync_out <= vs_s2;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed self-checking bench for vga_fb_arbiter.
// Honours VGA_ARB_VBLANK_ONLY_EN for the write-window check.
module tb_vga_fb_arbiter;

    logic        CLKIN = 1'b0;
    logic        reset;
    logic        clock_enable;
    logic        pixel_valid;
    logic [9:0]  vga_row;
    logic [9:0]  vga_col;
    logic        horizontal_sync;
    logic        vertical_sync;
    logic [18:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        wr_req;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_ack;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        hsync_out;
    logic        vsync_out;

    logic        use_forced;
    logic [7:0]  forced_rdata;
    logic [7:0]  model_q = 8'd0;

    int testCount = 0;
    int failCount = 0;

    vga_fb_arbiter dut (
        .CLKIN           (CLKIN),
        .reset           (reset),
        .clock_enable    (clock_enable),
        .pixel_valid     (pixel_valid),
        .vga_row         (vga_row),
        .vga_col         (vga_col),
        .horizontal_sync (horizontal_sync),
        .vertical_sync   (vertical_sync),
        .mem_addr        (mem_addr),
        .mem_we          (mem_we),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .wr_req          (wr_req),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .pix_data        (pix_data),
        .pix_valid       (pix_valid),
        .hsync_out       (hsync_out),
        .vsync_out       (vsync_out)
    );

    // Free-running clock, 10 time units per period.
    always #5 CLKIN = ~CLKIN;

    // Framebuffer model: data is a fixed function of the address, one enabled cycle late.
    always @(posedge CLKIN) begin
        if (clock_enable) model_q <= mem_addr[7:0] ^ 8'h5A;
    end

    assign mem_rdata = use_forced ? forced_rdata : model_q;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic pv, input int row, input int col,
                                 input logic hs, input logic vs);
        pixel_valid     = pv;
        vga_row         = 10'(row);
        vga_col         = 10'(col);
        horizontal_sync = hs;
        vertical_sync   = vs;
    endtask

    task automatic nextCycle();
        @(posedge CLKIN);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        clock_enable = 1'b1;
        use_forced   = 1'b0;
        forced_rdata = 8'd0;
        wr_req       = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        #1;
        nextCycle();
        nextCycle();

        // Reset state
        checkOutput("rst_mem_addr", 32'(mem_addr), 0);
        checkOutput("rst_mem_we", 32'(mem_we), 0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 0);
        checkOutput("rst_wr_ack", 32'(wr_ack), 0);
        checkOutput("rst_pix", 32'({pix_valid, pix_data, hsync_out, vsync_out}), 0);
        reset = 1'b0;
        nextCycle();

        // Single read: row 2, col 5 -> address 1285, data returns three cycles on
        applyStimulus(1'b1, 2, 5, 1'b1, 1'b0);
        nextCycle();
        checkOutput("rd_addr", 32'(mem_addr), 1285);
        checkOutput("rd_we", 32'(mem_we), 0);
        applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
        nextCycle();
        use_forced   = 1'b1;
        forced_rdata = 8'hA5;
        nextCycle();
        checkOutput("rd_pix_data", 32'(pix_data), 32'hA5);
        checkOutput("rd_pix_valid", 32'(pix_valid), 1);
        checkOutput("rd_hsync_align", 32'(hsync_out), 1);
        nextCycle();
        checkOutput("idle_pix_zero", 32'({pix_valid, pix_data}), 0);
        checkOutput("idle_hsync", 32'(hsync_out), 0);

        // Last visible pixel and an out-of-range pixel
        applyStimulus(1'b1, 479, 639, 1'b0, 1'b0);
        nextCycle();
        checkOutput("rd_addr_max", 32'(mem_addr), 307199);
        applyStimulus(1'b1, 480, 0, 1'b0, 1'b0);
        forced_rdata = 8'hFF;
        nextCycle();
        checkOutput("oor_we", 32'(mem_we), 0);
        applyStimulus(1'b0, 480, 0, 1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("oor_pix_valid", 32'(pix_valid), 1);
        checkOutput("oor_pix_data", 32'(pix_data), 0);
        use_forced = 1'b0;
        nextCycle();

        // Blanking write held high through WRITE and HOLD: exactly one write
        wr_req  = 1'b1;
        wr_addr = 19'h00010;
        wr_data = 8'h3C;
        nextCycle();
        checkOutput("wr_we", 32'(mem_we), 1);
        checkOutput("wr_ack", 32'(wr_ack), 1);
        checkOutput("wr_addr", 32'(mem_addr), 32'h10);
        checkOutput("wr_wdata", 32'(mem_wdata), 32'h3C);
        nextCycle();
        checkOutput("hold_we", 32'(mem_we), 0);
        checkOutput("hold_ack", 32'(wr_ack), 0);
        nextCycle();
        checkOutput("no_second_we", 32'(mem_we), 0);
        wr_req = 1'b0;
        nextCycle();
        checkOutput("no_second_we2", 32'(mem_we), 0);

        // Write requested during 10 active pixels waits for pixel_valid to fall
        wr_addr = 19'h00123;
        wr_data = 8'h77;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 10, i, 1'b0, 1'b0);
            if (i == 0) wr_req = 1'b1;
            nextCycle();
            checkOutput($sformatf("active_no_we_%0d", i), 32'(mem_we), 0);
            checkOutput($sformatf("active_addr_%0d", i), 32'(mem_addr), 6400 + i);
        end
        applyStimulus(1'b0, 480, 0, 1'b0, 1'b0);
        nextCycle();
        checkOutput("pend_we", 32'(mem_we), 1);
        checkOutput("pend_ack", 32'(wr_ack), 1);
        checkOutput("pend_addr", 32'(mem_addr), 32'h123);
        wr_req = 1'b0;
        nextCycle();
        checkOutput("pend_hold_we", 32'(mem_we), 0);
        nextCycle();
        nextCycle();

        // Reset in the write-decision cycle: no ack, pipeline flushed
        applyStimulus(1'b1, 0, 3, 1'b1, 1'b1);
        nextCycle();
        checkOutput("pre_rst_addr", 32'(mem_addr), 3);
        applyStimulus(1'b0, 480, 0, 1'b0, 1'b0);
        wr_req  = 1'b1;
        wr_addr = 19'h00055;
        wr_data = 8'h99;
        reset   = 1'b1;
        nextCycle();
        checkOutput("rst_wr_no_ack", 32'(wr_ack), 0);
        checkOutput("rst_wr_no_we", 32'(mem_we), 0);
        checkOutput("rst_wr_addr", 32'(mem_addr), 0);
        checkOutput("rst_wr_pix", 32'({pix_valid, pix_data, hsync_out, vsync_out}), 0);
        reset = 1'b0;
        nextCycle();
        checkOutput("rst_flush_pv1", 32'(pix_valid), 0);
        checkOutput("rst_flush_sync", 32'({hsync_out, vsync_out}), 0);
        checkOutput("rerequest_ack", 32'(wr_ack), 1);
        wr_req = 1'b0;
        nextCycle();
        checkOutput("rst_flush_pv2", 32'(pix_valid), 0);
        nextCycle();
        nextCycle();

        // Clock-enable stall mid-line; data = (addr low byte) ^ 0x5A, row 20 base 12800
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 20, c, 1'b0, 1'b0);
            nextCycle();
        end
        checkOutput("pre_stall_pix", 32'(pix_data), 32'h5A);
        checkOutput("pre_stall_pv", 32'(pix_valid), 1);
        applyStimulus(1'b1, 20, 3, 1'b0, 1'b0);
        clock_enable = 1'b0;
        for (int s = 0; s < 5; s++) begin
            nextCycle();
            checkOutput($sformatf("stall_pix_%0d", s), 32'(pix_data), 32'h5A);
            checkOutput($sformatf("stall_addr_%0d", s), 32'(mem_addr), 12802);
        end
        clock_enable = 1'b1;
        nextCycle();
        checkOutput("resume_pix", 32'(pix_data), 32'h5B);
        checkOutput("resume_addr", 32'(mem_addr), 12803);
        for (int c = 4; c < 9; c++) begin
            applyStimulus(c <= 5, 20, c, 1'b0, 1'b0);
            nextCycle();
            if (c <= 7) begin
                checkOutput($sformatf("resume_pix_c%0d", c - 2), 32'(pix_data), (c - 2) ^ 32'h5A);
                checkOutput($sformatf("resume_pv_c%0d", c - 2), 32'(pix_valid), 1);
            end else begin
                checkOutput("resume_end_pv", 32'({pix_valid, pix_data}), 0);
            end
        end

        // Write window: horizontal blanking on row 100
        applyStimulus(1'b0, 100, 700, 1'b1, 1'b0);
        wr_req  = 1'b1;
        wr_addr = 19'h00200;
        wr_data = 8'h11;
`ifdef VGA_ARB_VBLANK_ONLY_EN
        for (int s = 0; s < 3; s++) begin
            nextCycle();
            checkOutput($sformatf("vbl_block_we_%0d", s), 32'(mem_we), 0);
        end
        applyStimulus(1'b0, 480, 0, 1'b0, 1'b0);
`endif
        nextCycle();
        checkOutput("win_we", 32'(mem_we), 1);
        checkOutput("win_ack", 32'(wr_ack), 1);
        checkOutput("win_addr", 32'(mem_addr), 32'h200);
        wr_req = 1'b0;
        nextCycle();
        checkOutput("win_ack_single", 32'(wr_ack), 0);
        nextCycle();
        checkOutput("win_no_second", 32'(mem_we), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
